fmap_collector: RTL and testbench

- Streaming-to-array front end for the pooling stage.
- Accepts one signed feature-map element per cycle from the convolution engine over a valid/ready handshake.
- Optionally applies ReLU, and writes each element into a full channel x row x col register array.
- Once a complete frame is captured, holds it stable on `fmap` with `frame_valid` high until the downstream maxpool/consumer acknowledges it.

---
 rtl/fmap_collector.sv | 148 ++++++++++++++
 tb/tb_fmap_collector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_collector.sv
// fmap_collector: streaming-to-array front end for the pooling stage.
//
// Accepts one signed element per cycle over a valid/ready handshake. If ReluEn is set, it clamps
// negative elements to zero. Each element is written in raster, channel-major order into a full
// Channels x Rows x Cols register array. Once the last position is written, the frame is held
// stable on fmap_o with frame_valid_o high until frame_ack_i releases it.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         synchronous active-low reset
//   in_valid_i     upstream element valid
//   in_ready_o     collector can accept an element (high in FILL only)
//   in_data_i      signed element value
//   in_last_i      upstream marks final element of frame (checked, never used for framing)
//   fmap_o         captured frame [channel][row][col]
//   frame_valid_o  fmap_o holds a complete frame
//   frame_ack_i    consumer releases the frame
//   last_err_o     sticky: in_last_i disagreed with element position
module fmap_collector #(
    parameter int unsigned Channels = 1,
    parameter int unsigned Rows     = 27,
    parameter int unsigned Cols     = 27,
    parameter int unsigned DataSize = 8,
    parameter bit          ReluEn   = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [DataSize-1:0] in_data_i,
    input  logic                       in_last_i,
    output logic signed [DataSize-1:0] fmap_o [Channels][Rows][Cols],
    output logic                       frame_valid_o,
    input  logic                       frame_ack_i,
    output logic                       last_err_o
);

    // Counter widths: at least one bit so a dimension of 1 still has a counter.
    localparam int unsigned CW = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int unsigned RW = (Rows > 1) ? $clog2(Rows) : 1;
    localparam int unsigned KW = (Cols > 1) ? $clog2(Cols) : 1;

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                     state_q;
    logic [CW-1:0]              c_q, c_d;
    logic [RW-1:0]              r_q, r_d;
    logic [KW-1:0]              k_q, k_d;
    logic                       frame_valid_q;
    logic                       last_err_q;
    logic signed [DataSize-1:0] fmap_q [Channels][Rows][Cols];

    logic                       accept;
    logic                       k_end, r_end, c_end, final_pos;
    logic                       last_bad;
    logic signed [DataSize-1:0] store_val;

    // in_ready depends on state alone, so it never loops back from in_valid.
    assign in_ready_o    = (state_q == StFill);
    assign frame_valid_o = frame_valid_q;
    assign last_err_o    = last_err_q;
    assign fmap_o        = fmap_q;

    always_comb begin
        accept    = in_valid_i && (state_q == StFill);
        k_end     = (k_q == KW'(Cols - 1));
        r_end     = (r_q == RW'(Rows - 1));
        c_end     = (c_q == CW'(Channels - 1));
        final_pos = c_end && r_end && k_end;
        last_bad  = (in_last_i != final_pos);
        store_val = (ReluEn && in_data_i[DataSize-1]) ? '0 : in_data_i;

        c_d = c_q;
        r_d = r_q;
        k_d = k_q;
        if (accept) begin
            if (k_end) begin
                k_d = '0;
                if (r_end) begin
                    r_d = '0;
                    c_d = c_end ? '0 : c_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StFill;
            c_q           <= '0;
            r_q           <= '0;
            k_q           <= '0;
            frame_valid_q <= 1'b0;
            last_err_q    <= 1'b0;
            for (int unsigned c = 0; c < Channels; c++) begin
                for (int unsigned r = 0; r < Rows; r++) begin
                    for (int unsigned k = 0; k < Cols; k++) begin
                        fmap_q[c][r][k] <= '0;
                    end
                end
            end
        end else begin
            c_q <= c_d;
            r_q <= r_d;
            k_q <= k_d;

            if (accept && last_bad) begin
                last_err_q <= 1'b1;
            end

            case (state_q)
                StFill: begin
                    if (accept && final_pos) begin
                        state_q       <= StHold;
                        frame_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    // No accept on the release edge: in_ready only rises next cycle.
                    if (frame_ack_i) begin
                        state_q       <= StFill;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= StFill;
                    frame_valid_q <= 1'b0;
                end
            endcase

            // Position decode by comparison keeps indexing in range for any dimension size.
            for (int unsigned c = 0; c < Channels; c++) begin
                for (int unsigned r = 0; r < Rows; r++) begin
                    for (int unsigned k = 0; k < Cols; k++) begin
                        if (accept && (c_q == CW'(c)) && (r_q == RW'(r)) && (k_q == KW'(k))) begin
                            fmap_q[c][r][k] <= store_val;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fmap_collector.sv
module tb_fmap_collector;

    logic clk;
    logic rst_n;

    // DUT A: default 1x27x27, ReLU on.
    logic              a_valid, a_last, a_ack;
    logic signed [7:0] a_data;
    logic              a_ready, a_fv, a_err;
    logic signed [7:0] a_fmap [1][27][27];

    // DUT B: 2x3x3, ReLU off.
    logic              b_valid, b_last, b_ack;
    logic signed [7:0] b_data;
    logic              b_ready, b_fv, b_err;
    logic signed [7:0] b_fmap [2][3][3];

    int tests = 0;
    int fails = 0;

    int exp_a_q[$];
    int exp_b_q[$];
    int exp_a[729];

    fmap_collector dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (a_valid),
        .in_ready_o   (a_ready),
        .in_data_i    (a_data),
        .in_last_i    (a_last),
        .fmap_o       (a_fmap),
        .frame_valid_o(a_fv),
        .frame_ack_i  (a_ack),
        .last_err_o   (a_err)
    );

    fmap_collector #(
        .Channels(2),
        .Rows    (3),
        .Cols    (3),
        .DataSize(8),
        .ReluEn  (1'b0)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (b_valid),
        .in_ready_o   (b_ready),
        .in_data_i    (b_data),
        .in_last_i    (b_last),
        .fmap_o       (b_fmap),
        .frame_valid_o(b_fv),
        .frame_ack_i  (b_ack),
        .last_err_o   (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [7:0] gen(input int i, input int mode);
        case (mode)
            0:       return 8'(i);
            1:       return 8'(3 * i + 1);
            default: return 8'sd7;
        endcase
    endfunction

    function automatic int relu(input logic signed [7:0] v);
        return (v < 0) ? 0 : int'(v);
    endfunction

    function automatic int a_nonzero();
        int n;
        n = 0;
        for (int i = 0; i < 729; i++) if (a_fmap[0][i/27][i%27] != 0) n++;
        return n;
    endfunction

    function automatic int a_diff();
        int n;
        n = 0;
        for (int i = 0; i < 729; i++) if (int'(a_fmap[0][i/27][i%27]) != exp_a[i]) n++;
        return n;
    endfunction

    // Scoreboard monitors: compare the whole array when frame_valid rises.
    initial begin : mon_a
        bit prev;
        int bad, first, act, e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (a_fv && !prev) begin
                if (exp_a_q.size() < 729) begin
                    check("mon_a_unexpected_frame", exp_a_q.size(), 729);
                end else begin
                    bad = 0;
                    first = -1;
                    act = 0;
                    for (int i = 0; i < 729; i++) begin
                        e = exp_a_q.pop_front();
                        if (int'(a_fmap[0][i/27][i%27]) != e) begin
                            if (bad == 0) begin
                                first = i;
                                act = int'(a_fmap[0][i/27][i%27]);
                            end
                            bad++;
                        end
                    end
                    if (bad != 0) $display("  first bad index %0d: got %0d", first, act);
                    check("mon_a_frame_mismatches", bad, 0);
                end
            end
            prev = a_fv;
        end
    end

    initial begin : mon_b
        bit prev;
        int bad, e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (b_fv && !prev) begin
                if (exp_b_q.size() < 18) begin
                    check("mon_b_unexpected_frame", exp_b_q.size(), 18);
                end else begin
                    bad = 0;
                    for (int i = 0; i < 18; i++) begin
                        e = exp_b_q.pop_front();
                        if (int'(b_fmap[i/9][(i%9)/3][i%3]) != e) bad++;
                    end
                    check("mon_b_frame_mismatches", bad, 0);
                end
            end
            prev = b_fv;
        end
    end

    // Present one beat at a negedge; it is accepted at the following posedge.
    task automatic send_a(input logic signed [7:0] d, input bit last, input bit gaps);
        int n;
        if (gaps) begin
            a_valid = 1'b0;
            n = 0;
            while ($urandom_range(0, 1) == 1 && n < 4) begin
                @(negedge clk);
                n++;
            end
        end
        a_valid = 1'b1;
        a_data  = d;
        a_last  = last;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("a_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_b(input logic signed [7:0] d, input bit last);
        int n;
        b_valid = 1'b1;
        b_data  = d;
        b_last  = last;
        n = 0;
        while (!b_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("b_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic frame_a(input int mode, input bit gaps, input int bad_idx);
        logic signed [7:0] v;
        for (int i = 0; i < 729; i++) begin
            v = gen(i, mode);
            exp_a[i] = relu(v);
            exp_a_q.push_back(relu(v));
        end
        for (int i = 0; i < 729; i++) begin
            if (i == 728) check("a_fv_low_before_last", a_fv, 0);
            send_a(gen(i, mode), (i == 728) || (i == bad_idx), gaps);
            if (bad_idx == 10 && i == 9) check("a_err_before_bad_last", a_err, 0);
            if (bad_idx == 10 && i == 10) check("a_err_after_bad_last", a_err, 1);
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
        check("a_fv_after_last", a_fv, 1);
        check("a_ready_in_hold", a_ready, 0);
    endtask

    task automatic ack_a();
        a_ack = 1'b1;
        @(negedge clk);
        a_ack = 1'b0;
        check("a_fv_after_ack", a_fv, 0);
        check("a_ready_after_ack", a_ready, 1);
    endtask

    initial begin : main
        int bad;
        rst_n = 1'b0;
        a_valid = 1'b1; a_data = 8'sd55; a_last = 1'b0; a_ack = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b0;
        check("reset_ready", a_ready, 1);
        check("reset_fv", a_fv, 0);
        check("reset_err", a_err, 0);
        check("reset_fmap_nonzero", a_nonzero(), 0);

        // Frame 1: index mod 256, ReLU, no gaps.
        frame_a(0, 1'b0, -1);
        check("a_fmap_0_4_20_relu", int'(a_fmap[0][4][20]), 0);
        check("a_fmap_0_3_7", int'(a_fmap[0][3][7]), 88);
        check("a_err_clean_frame", a_err, 0);

        // Beats offered during HOLD are ignored.
        a_valid = 1'b1; a_data = 8'sd99; a_last = 1'b1;
        repeat (5) @(negedge clk);
        a_valid = 1'b0; a_last = 1'b0;
        check("a_hold_fmap_changed", a_diff(), 0);
        check("a_hold_fv", a_fv, 1);
        check("a_hold_err", a_err, 0);
        ack_a();
        check("a_after_ack_fmap_kept", a_diff(), 0);

        // Frame 2: same data with random gaps.
        frame_a(0, 1'b1, -1);
        ack_a();

        // Frame 3: misplaced in_last on beat 10.
        frame_a(1, 1'b0, 10);
        ack_a();
        check("a_err_sticky_after_ack", a_err, 1);

        // Partial fill, then reset, then a clean frame.
        for (int i = 0; i < 300; i++) send_a(gen(i, 2), 1'b0, 1'b0);
        a_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_err_cleared", a_err, 0);
        check("midreset_fv", a_fv, 0);
        check("midreset_fmap_nonzero", a_nonzero(), 0);
        frame_a(0, 1'b0, -1);
        check("a_final_err", a_err, 0);
        ack_a();

        // DUT B frame A: all -5.
        for (int i = 0; i < 18; i++) exp_b_q.push_back(-5);
        for (int i = 0; i < 18; i++) send_b(-8'sd5, i == 17);
        b_valid = 1'b0;
        check("b_fv_frame_a", b_fv, 1);
        b_ack = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        check("b_ready_after_ack", b_ready, 1);

        // DUT B frame B: 1..18, with an ack pulse during FILL.
        for (int i = 0; i < 18; i++) exp_b_q.push_back(i + 1);
        for (int i = 0; i < 18; i++) begin
            b_ack = (i == 3);
            send_b(8'(i + 1), i == 17);
            b_ack = 1'b0;
            if (i == 4) check("b_ready_ack_in_fill", b_ready, 1);
            if (i == 8) begin
                bad = 0;
                for (int j = 0; j < 9; j++) if (int'(b_fmap[1][j/3][j%3]) != -5) bad++;
                check("b_ch1_still_old", bad, 0);
                check("b_fmap_0_2_2_mid", int'(b_fmap[0][2][2]), 9);
                check("b_fv_mid", b_fv, 0);
            end
        end
        b_valid = 1'b0;
        check("b_fv_frame_b", b_fv, 1);
        check("b_fmap_1_2_2", int'(b_fmap[1][2][2]), 18);
        check("b_fmap_0_0_0", int'(b_fmap[0][0][0]), 1);
        check("b_err", b_err, 0);

        repeat (3) @(negedge clk);
        check("a_scoreboard_drained", exp_a_q.size(), 0);
        check("b_scoreboard_drained", exp_b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
